// File: rtl/vote_collect_if.sv
// Ballot/result bundle between a ballot producer and vote_collect.
//   start, abort        : round control from the producer
//   ballot_valid/ballot : ballot handshake, data is W bits
//   ballot_ready        : collector accepts a ballot this cycle
//   result/result_valid : registered bitwise majority, one-cycle update pulse
//   busy, count         : round in progress, ballots accepted so far
interface vote_collect_if #(
  parameter int unsigned W = 3
);
  logic         start;
  logic         abort;
  logic         ballot_valid;
  logic [W-1:0] ballot;
  logic         ballot_ready;
  logic [W-1:0] result;
  logic         result_valid;
  logic         busy;
  logic [2:0]   count;

  modport master (
    output start, abort, ballot_valid, ballot,
    input  ballot_ready, result, result_valid, busy, count
  );

  modport slave (
    input  start, abort, ballot_valid, ballot,
    output ballot_ready, result, result_valid, busy, count
  );
endinterface

// File: rtl/vote_collect.sv
// Collects NVOTER ballots of W bits and produces a per-bit majority result.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   vote_io : vote_collect_if slave (start/abort, ballot handshake, result,
//             result_valid, busy, count)
// The result register is loaded on the edge that accepts the last ballot, so
// result is already updated in the DONE cycle where result_valid is high.
module vote_collect #(
  parameter int unsigned NVOTER = 5,
  parameter int unsigned W      = 3
) (
  input logic           clk,
  input logic           rst_n,
  vote_collect_if.slave vote_io
);

  localparam logic [2:0] LastCount = 3'(NVOTER - 1);
  localparam logic [2:0] Threshold = 3'((NVOTER + 1) / 2);

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e             state_q, state_d;
  logic [2:0]         count_q, count_d;
  logic [W-1:0][2:0]  tally_q, tally_d;
  logic [W-1:0]       result_q, result_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      tally_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tally_q  <= tally_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    tally_d  = tally_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (vote_io.start) begin
          count_d = '0;
          tally_d = '0;
          state_d = StCollect;
        end
      end
      StCollect: begin
        // Abort wins over a ballot offered in the same cycle.
        if (vote_io.abort) begin
          count_d = '0;
          tally_d = '0;
          state_d = StIdle;
        end else if (vote_io.ballot_valid) begin
          count_d = count_q + 3'd1;
          for (int unsigned i = 0; i < W; i++) begin
            tally_d[i] = tally_q[i] + 3'(vote_io.ballot[i]);
          end
          if (count_q == LastCount) begin
            state_d = StDone;
            for (int unsigned i = 0; i < W; i++) begin
              result_d[i] = (tally_d[i] >= Threshold);
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign vote_io.ballot_ready = (state_q == StCollect);
  assign vote_io.busy         = (state_q != StIdle);
  assign vote_io.result_valid = (state_q == StDone);
  assign vote_io.result       = result_q;
  assign vote_io.count        = count_q;

endmodule

// File: tb/tb_vote_collect.sv
// Directed, table-driven bench for vote_collect (NVOTER=5, W=3).
module tb_vote_collect;

  logic clk;
  logic rst_n;

  vote_collect_if #(.W(3)) vote_io ();

  vote_collect #(
    .NVOTER(5),
    .W     (3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .vote_io(vote_io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       abort;
    logic       valid;
    logic [2:0] ballot;
    logic       exp_ready;
    logic [2:0] exp_count;
    logic       exp_busy;
    logic       exp_rv;
    logic [2:0] exp_result;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic ab, input logic vl, input logic [2:0] b,
                     input logic rdy, input logic [2:0] cnt, input logic bsy, input logic rv,
                     input logic [2:0] res);
    vec_t v;
    v.start = st; v.abort = ab; v.valid = vl; v.ballot = b;
    v.exp_ready = rdy; v.exp_count = cnt; v.exp_busy = bsy; v.exp_rv = rv;
    v.exp_result = res;
    vecs.push_back(v);
  endtask

  // Full round: start, five ballots (with optional idle gaps), one idle cycle.
  task automatic add_round(input logic [2:0] b0, input logic [2:0] b1, input logic [2:0] b2,
                           input logic [2:0] b3, input logic [2:0] b4,
                           input logic [2:0] prev, input logic [2:0] nres, input int gaps);
    logic [2:0] b[5];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4;
    add(1, 0, 0, 3'b000, 1, 3'd0, 1, 0, prev);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        add(0, 0, 1, b[k], 1, 3'(k + 1), 1, 0, prev);
        // Garbage on ballot while valid is low must not be counted.
        for (int g = 0; g < gaps; g++) add(0, 0, 0, 3'b111, 1, 3'(k + 1), 1, 0, prev);
      end else begin
        add(0, 0, 1, b[k], 0, 3'd5, 1, 1, nres);
      end
    end
    add(0, 0, 0, 3'b000, 0, 3'd5, 0, 0, nres);
  endtask

  task automatic drive(input logic st, input logic ab, input logic vl, input logic [2:0] b);
    vote_io.start        = st;
    vote_io.abort        = ab;
    vote_io.ballot_valid = vl;
    vote_io.ballot       = b;
  endtask

  task automatic chk_outs(input string tag, input logic rdy, input logic [2:0] cnt,
                          input logic bsy, input logic rv, input logic [2:0] res);
    chk({tag, ".ready"}, 32'(vote_io.ballot_ready), 32'(rdy));
    chk({tag, ".count"}, 32'(vote_io.count), 32'(cnt));
    chk({tag, ".busy"}, 32'(vote_io.busy), 32'(bsy));
    chk({tag, ".result_valid"}, 32'(vote_io.result_valid), 32'(rv));
    chk({tag, ".result"}, 32'(vote_io.result), 32'(res));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Basic majority round.
    add_round(3'b101, 3'b110, 3'b100, 3'b011, 3'b001, 3'b000, 3'b101, 0);
    // Tie boundary on bit 2: two of five -> 0, three of five -> 1.
    add_round(3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 3'b101, 3'b000, 0);
    add_round(3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 0);
    // Same ballots as the basic round with two-cycle gaps.
    add_round(3'b101, 3'b110, 3'b100, 3'b011, 3'b001, 3'b100, 3'b101, 2);
    // Abort with a simultaneous fourth ballot; result must survive.
    add(1, 0, 0, 3'b000, 1, 3'd0, 1, 0, 3'b101);
    add(0, 0, 1, 3'b111, 1, 3'd1, 1, 0, 3'b101);
    add(0, 0, 1, 3'b111, 1, 3'd2, 1, 0, 3'b101);
    add(0, 0, 1, 3'b111, 1, 3'd3, 1, 0, 3'b101);
    add(0, 1, 1, 3'b111, 0, 3'd0, 0, 0, 3'b101);
    add(0, 1, 0, 3'b000, 0, 3'd0, 0, 0, 3'b101);   // abort in IDLE ignored
    add(1, 1, 0, 3'b000, 1, 3'd0, 1, 0, 3'b101);   // start still taken with abort
    add(0, 0, 1, 3'b000, 1, 3'd1, 1, 0, 3'b101);
    add(0, 0, 1, 3'b000, 1, 3'd2, 1, 0, 3'b101);
    add(0, 0, 1, 3'b000, 1, 3'd3, 1, 0, 3'b101);
    add(0, 0, 1, 3'b000, 1, 3'd4, 1, 0, 3'b101);
    add(0, 0, 1, 3'b000, 0, 3'd5, 1, 1, 3'b000);
    add(0, 0, 0, 3'b000, 0, 3'd5, 0, 0, 3'b000);
    // Start while busy is ignored; also start in DONE is ignored.
    add(1, 0, 0, 3'b000, 1, 3'd0, 1, 0, 3'b000);
    add(0, 0, 1, 3'b010, 1, 3'd1, 1, 0, 3'b000);
    add(0, 0, 1, 3'b010, 1, 3'd2, 1, 0, 3'b000);
    add(1, 0, 0, 3'b000, 1, 3'd2, 1, 0, 3'b000);
    add(0, 0, 1, 3'b010, 1, 3'd3, 1, 0, 3'b000);
    add(0, 0, 1, 3'b010, 1, 3'd4, 1, 0, 3'b000);
    add(0, 0, 1, 3'b010, 0, 3'd5, 1, 1, 3'b010);
    add(1, 0, 0, 3'b000, 0, 3'd5, 0, 0, 3'b010);
    add(0, 0, 0, 3'b000, 0, 3'd5, 0, 0, 3'b010);

    // Reset state.
    rst_n = 1'b0;
    drive(0, 0, 0, 3'b000);
    #2;
    chk_outs("reset", 0, 3'd0, 0, 0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].start, vecs[i].abort, vecs[i].valid, vecs[i].ballot);
      @(posedge clk);
      #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_count, vecs[i].exp_busy,
               vecs[i].exp_rv, vecs[i].exp_result);
    end

    // Reset mid-round after two ballots.
    @(negedge clk);
    drive(1, 0, 0, 3'b000);
    @(negedge clk);
    drive(0, 0, 1, 3'b111);
    @(negedge clk);
    @(negedge clk);
    chk("midrst.count_before", 32'(vote_io.count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("midrst.async", 0, 3'd0, 0, 0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_outs("midrst.idle", 0, 3'd0, 0, 0, 3'b000);

    // Start on the first edge after reset release.
    @(negedge clk);
    drive(0, 0, 0, 3'b000);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    drive(1, 0, 0, 3'b000);
    @(posedge clk);
    #1;
    chk_outs("rst_start", 1, 3'd0, 1, 0, 3'b000);
    drive(0, 0, 0, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vote_collect.md
VOTE_COLLECT -- requirements
Module: vote_collect

Interface
REQ-001 SHALL have parameter NVOTER, default 5, meaning the number of ballots per round (odd, 3..7).
REQ-002 SHALL have parameter W, default 3, meaning the ballot width in bits, with each bit voted independently.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  opens a new voting round when the block is idle.
REQ-006 SHALL have port abort  input  1  discards the round in progress.
REQ-007 SHALL have port ballot_valid  input  1  producer presents a ballot.
REQ-008 SHALL have port ballot  input  W  ballot data; bit i is a vote for position i.
REQ-009 SHALL have port ballot_ready  output  1  block accepts a ballot this cycle.
REQ-010 SHALL have port result  output  W  registered bitwise majority of the last completed round.
REQ-011 SHALL have port result_valid  output  1  single-cycle pulse when result updates.
REQ-012 SHALL have port busy  output  1  round in progress (COLLECT or DONE state).
REQ-013 SHALL have port count  output  3  number of ballots accepted in the current round.

Function
REQ-014 SHALL implement the FSM states IDLE, COLLECT and DONE.
REQ-015 SHALL, in IDLE with start=1, clear count and all per-bit tallies and enter COLLECT on the next edge.
REQ-016 SHALL drive ballot_ready=1 only in COLLECT; it SHALL be 0 in IDLE and DONE.
REQ-017 SHALL treat a ballot as accepted when ballot_valid=1 and ballot_ready=1 on a rising edge. On acceptance, count SHALL increment by 1 and tally[i] SHALL increment by 1 for each ballot[i]=1.
REQ-018 SHALL size each tally[i] at 3 bits unsigned; because count never exceeds NVOTER, tallies cannot overflow.
REQ-019 SHALL hold count and tallies when ballot_valid=0; this is not an error.
REQ-020 SHALL enter DONE on the same edge that accepts ballot number NVOTER.
REQ-021 SHALL, in DONE, register result[i] = (tally[i] >= (NVOTER+1)/2), assert result_valid for exactly one cycle, and return to IDLE on the next edge.
REQ-022 SHALL make latency exactly 1 cycle: result_valid is high in the cycle after the edge that accepted the last ballot.
REQ-023 SHALL hold result after DONE until the next DONE; it SHALL NOT be cleared by start or abort.
REQ-024 SHALL ignore start in COLLECT and DONE.
REQ-025 SHALL, on abort=1 in COLLECT, return to IDLE on the next edge, clear count and tallies, leave result unchanged, and produce no result_valid pulse.
REQ-026 SHALL give abort priority over a simultaneous ballot acceptance; that ballot is dropped.
REQ-027 SHALL ignore abort in IDLE and DONE.
REQ-028 SHALL drive busy=1 in COLLECT and DONE, and busy=0 in IDLE.

Reset
REQ-029 SHALL, on rst_n=0, immediately (asynchronously) force state=IDLE, count=0, tallies=0, result=0, result_valid=0, ballot_ready=0 and busy=0.
REQ-030 SHALL discard all partial tallies on a reset asserted mid-round; after release the block SHALL wait in IDLE for start.
REQ-031 SHALL accept start on the first rising edge after rst_n deasserts.

Verification
REQ-032 Bench SHALL cover a basic majority round: start, then ballots 3'b101, 3'b110, 3'b100, 3'b011, 3'b001 with valid held high -> count steps 1..5, result=3'b101, result_valid high for one cycle exactly one cycle after the 5th accept, then busy=0.
REQ-033 Bench SHALL cover gaps: the same 5 ballots with ballot_valid=0 for 2 cycles between each -> identical result 3'b101 and no extra result_valid pulses.
REQ-034 Bench SHALL cover abort: start, 3 ballots 3'b111, then abort together with a 4th ballot_valid -> count=0, state IDLE, result keeps its prior value, no pulse; a following full round of 3'b000 ballots yields result=3'b000.
REQ-035 Bench SHALL cover reset mid-round: rst_n low after 2 ballots -> all outputs 0 within the same cycle; after release, ballot_valid=1 in IDLE sees ballot_ready=0 and count stays 0.
REQ-036 Bench SHALL cover start while busy: start pulsed during COLLECT after 2 ballots -> no effect, and the round completes after 3 more ballots.
REQ-037 Bench SHALL cover a tie boundary: exactly 3 of 5 ballots with bit 2 set -> result[2]=1; exactly 2 of 5 -> result[2]=0.
